// File: rtl/n_bit_d_register.sv
// n_bit_d_register: N-bit edge-triggered D register with load enable,
// synchronous active-high reset and a complementary output.
//
// Built from N identical single-bit cells. Each cell is a D flip-flop whose
// next state selects between holding its bit and loading D[i] under En, with
// reset taking priority over the load.
//
// Parameters:
//   N          data width in bits (1..64)
//   RESET_VAL  value loaded into Q on reset
//
// Ports:
//   Clk  in   rising-edge clock
//   R    in   synchronous reset, active-high, wins over En
//   En   in   load enable, active-high; 0/X/Z all hold
//   D    in   N-bit data to load
//   Q    out  N-bit stored value
//   Qn   out  bitwise complement of Q (combinational, no extra storage)
//   P    out  registered even parity of Q (only with NBIT_DREG_PARITY_EN)
//
// Build option: define NBIT_DREG_PARITY_EN to add the parity output P.

module n_bit_d_register #(
    parameter int unsigned   N         = 8,
    parameter logic [N-1:0]  RESET_VAL = '0
) (
    input  logic         Clk,
    input  logic         R,
    input  logic         En,
    input  logic [N-1:0] D,
`ifdef NBIT_DREG_PARITY_EN
    output logic         P,
`endif
    output logic [N-1:0] Q,
    output logic [N-1:0] Qn
);

    logic [N-1:0] q_q;

    for (genvar i = 0; i < N; i++) begin : g_cell
        logic bit_d;
        logic bit_q;

        // An if on En takes the hold branch for X/Z as well as 0, so a
        // floating enable never disturbs the stored bit.
        always_comb begin
            bit_d = bit_q;
            if (En == 1'b1) begin
                bit_d = D[i];
            end
        end

        always_ff @(posedge Clk) begin
            if (R == 1'b1) begin
                bit_q <= RESET_VAL[i];
            end else begin
                bit_q <= bit_d;
            end
        end

        assign q_q[i] = bit_q;
    end

    assign Q  = q_q;
    assign Qn = ~q_q;

`ifdef NBIT_DREG_PARITY_EN
    logic p_d;
    logic p_q;

    // Parity of the value Q is about to take, so P tracks ^Q without a lag.
    always_comb begin
        p_d = p_q;
        if (En == 1'b1) begin
            p_d = ^D;
        end
    end

    always_ff @(posedge Clk) begin
        if (R == 1'b1) begin
            p_q <= ^RESET_VAL;
        end else begin
            p_q <= p_d;
        end
    end

    assign P = p_q;
`endif

endmodule

// File: tb/tb_n_bit_d_register.sv
// Directed testbench for n_bit_d_register: a 32-bit instance with default
// reset value and an 8-bit instance with RESET_VAL = 8'hA5.

module tb_n_bit_d_register;

    logic        clk;
    logic        r32, en32;
    logic [31:0] d32;
    logic [31:0] q32, qn32;
    logic        r8, en8;
    logic [7:0]  d8;
    logic [7:0]  q8, qn8;
`ifdef NBIT_DREG_PARITY_EN
    logic        p32;
    logic        p8;
`endif

    int checks;
    int failures;

    n_bit_d_register #(
        .N         (32),
        .RESET_VAL (32'h0)
    ) dut32 (
        .Clk (clk),
        .R   (r32),
        .En  (en32),
        .D   (d32),
`ifdef NBIT_DREG_PARITY_EN
        .P   (p32),
`endif
        .Q   (q32),
        .Qn  (qn32)
    );

    n_bit_d_register #(
        .N         (8),
        .RESET_VAL (8'hA5)
    ) dut8 (
        .Clk (clk),
        .R   (r8),
        .En  (en8),
        .D   (d8),
`ifdef NBIT_DREG_PARITY_EN
        .P   (p8),
`endif
        .Q   (q8),
        .Qn  (qn8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive inputs while the clock is low.
    task automatic to_low();
        @(negedge clk);
    endtask

    task automatic test_reset();
        to_low();
        r32 = 1'b1; en32 = 1'b0; d32 = 32'd7;
        tick();
        checks++;
        if (q32 !== 32'h0) begin
            failures++;
            $display("FAIL reset_q got=%h want=%h", q32, 32'h0);
        end
        checks++;
        if (qn32 !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL reset_qn got=%h want=%h", qn32, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_load();
        to_low();
        r32 = 1'b0; en32 = 1'b1; d32 = 32'd7;
        tick();
        checks++;
        if (q32 !== 32'd7) begin
            failures++;
            $display("FAIL load_q got=%h want=%h", q32, 32'd7);
        end
        checks++;
        if (qn32 !== 32'hFFFF_FFF8) begin
            failures++;
            $display("FAIL load_qn got=%h want=%h", qn32, 32'hFFFF_FFF8);
        end
        // D changes between edges must not reach Q.
        to_low();
        d32 = 32'd9;
        #2;
        checks++;
        if (q32 !== 32'd7) begin
            failures++;
            $display("FAIL between_edges_q got=%h want=%h", q32, 32'd7);
        end
        en32 = 1'b0;
        tick();
        checks++;
        if (q32 !== 32'd7) begin
            failures++;
            $display("FAIL en_drop_q got=%h want=%h", q32, 32'd7);
        end
    endtask

    task automatic test_hold();
        to_low();
        en32 = 1'b0; d32 = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q32 !== 32'd7) begin
                failures++;
                $display("FAIL hold_q edge=%0d got=%h want=%h", i, q32, 32'd7);
            end
        end
        to_low();
        en32 = 1'bz;
        tick();
        checks++;
        if (q32 !== 32'd7) begin
            failures++;
            $display("FAIL hold_en_z_q got=%h want=%h", q32, 32'd7);
        end
        checks++;
        if (qn32 !== 32'hFFFF_FFF8) begin
            failures++;
            $display("FAIL hold_en_z_qn got=%h want=%h", qn32, 32'hFFFF_FFF8);
        end
    endtask

    task automatic test_priority();
        to_low();
        r32 = 1'b1; en32 = 1'b1; d32 = 32'h1234_5678;
        tick();
        checks++;
        if (q32 !== 32'h0) begin
            failures++;
            $display("FAIL prio_reset_q got=%h want=%h", q32, 32'h0);
        end
        to_low();
        r32 = 1'b0;
        tick();
        checks++;
        if (q32 !== 32'h1234_5678) begin
            failures++;
            $display("FAIL prio_release_q got=%h want=%h", q32, 32'h1234_5678);
        end
        checks++;
        if (qn32 !== 32'hEDCB_A987) begin
            failures++;
            $display("FAIL prio_release_qn got=%h want=%h", qn32, 32'hEDCB_A987);
        end
    endtask

    task automatic test_back_to_back();
        to_low();
        en32 = 1'b1; d32 = 32'hA5A5_0001;
        tick();
        checks++;
        if (q32 !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL b2b_first got=%h want=%h", q32, 32'hA5A5_0001);
        end
        to_low();
        d32 = 32'h5A5A_FFFE;
        tick();
        checks++;
        if (q32 !== 32'h5A5A_FFFE) begin
            failures++;
            $display("FAIL b2b_second got=%h want=%h", q32, 32'h5A5A_FFFE);
        end
        checks++;
        if (qn32 !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL b2b_second_qn got=%h want=%h", qn32, 32'hA5A5_0001);
        end
    endtask

    task automatic test_params();
        to_low();
        r8 = 1'b1; en8 = 1'b0; d8 = 8'h00;
        tick();
        checks++;
        if (q8 !== 8'hA5) begin
            failures++;
            $display("FAIL param_reset_q got=%h want=%h", q8, 8'hA5);
        end
        checks++;
        if (qn8 !== 8'h5A) begin
            failures++;
            $display("FAIL param_reset_qn got=%h want=%h", qn8, 8'h5A);
        end
        to_low();
        r8 = 1'b0; en8 = 1'b1; d8 = 8'hFF;
        tick();
        checks++;
        if (q8 !== 8'hFF) begin
            failures++;
            $display("FAIL param_load_q got=%h want=%h", q8, 8'hFF);
        end
        checks++;
        if (qn8 !== 8'h00) begin
            failures++;
            $display("FAIL param_load_qn got=%h want=%h", qn8, 8'h00);
        end
    endtask

`ifdef NBIT_DREG_PARITY_EN
    task automatic test_parity();
        to_low();
        r32 = 1'b0; en32 = 1'b1; d32 = 32'h7;
        tick();
        checks++;
        if (p32 !== 1'b1) begin
            failures++;
            $display("FAIL parity_7 got=%b want=%b", p32, 1'b1);
        end
        to_low();
        d32 = 32'h3;
        tick();
        checks++;
        if (p32 !== 1'b0) begin
            failures++;
            $display("FAIL parity_3 got=%b want=%b", p32, 1'b0);
        end
        to_low();
        d32 = 32'h1;
        tick();
        to_low();
        en32 = 1'b0; d32 = 32'h3;
        tick();
        checks++;
        if (p32 !== 1'b1) begin
            failures++;
            $display("FAIL parity_hold got=%b want=%b", p32, 1'b1);
        end
        to_low();
        r32 = 1'b1;
        tick();
        checks++;
        if (p32 !== 1'b0) begin
            failures++;
            $display("FAIL parity_reset got=%b want=%b", p32, 1'b0);
        end
        r32 = 1'b0;
        // RESET_VAL 8'hA5 has four ones: even parity 0.
        to_low();
        r8 = 1'b1;
        tick();
        checks++;
        if (p8 !== 1'b0) begin
            failures++;
            $display("FAIL parity8_reset got=%b want=%b", p8, 1'b0);
        end
        r8 = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        r32 = 1'b0; en32 = 1'b0; d32 = '0;
        r8 = 1'b0; en8 = 1'b0; d8 = '0;
        test_reset();
        test_load();
        test_hold();
        test_priority();
        test_back_to_back();
        test_params();
`ifdef NBIT_DREG_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
